// File: rtl/tia_bus_writer_pkg.sv
// Shared constants, state encoding and command record for the TIA bus writer.
package tia_bus_writer_pkg;

    localparam int         CPU_PHASES     = 3;
    localparam logic [5:0] IDLE_ADDR_DEF  = 6'h3f;
    localparam logic [5:0] WSYNC_ADDR_DEF = 6'h02;
    localparam int         CMD_W          = 14;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } cmd_t;

endpackage

// File: rtl/tia_bus_writer_fifo.sv
// Command FIFO with show-ahead head entry so the bus registers can load it on the pop edge.
module tia_cmd_fifo
    import tia_bus_writer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_bar,
    input  logic          push,
    input  cmd_t          push_data,
    input  logic          pop,
    output cmd_t          pop_data,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok  = push && (level_reg != LW'(DEPTH));
    assign pop_ok   = pop && (level_reg != '0);
    assign pop_data = mem[rd_ptr_reg];
    assign level    = level_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/tia_bus_writer.sv
// Replays queued TIA register writes as 3-clk 6507 bus cycles, halting after WSYNC until rdy.
module tia_bus_writer
    import tia_bus_writer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [5:0] IDLE_ADDR  = IDLE_ADDR_DEF,
    parameter logic [5:0] WSYNC_ADDR = WSYNC_ADDR_DEF,
    parameter int         CYCLE_W    = 16,
    parameter int         LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_bar,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [5:0]         cmd_addr,
    input  logic [7:0]         cmd_data,
    input  logic               rdy,
    output logic [5:0]         a,
    output logic [7:0]         d,
    output logic               w_bar,
    output logic               phi2,
    output logic [CYCLE_W-1:0] cpu_cycle,
    output logic               stalled,
    output logic [LW-1:0]      fifo_level
);
    logic [1:0]         ph_reg, ph_next;
    state_t             state_reg, state_next;
    logic [5:0]         a_reg, a_next;
    logic [7:0]         d_reg, d_next;
    logic               w_bar_reg, w_bar_next;
    logic [CYCLE_W-1:0] cycle_reg, cycle_next;
    logic               ready_en_reg;
    logic               boundary;
    logic               push;
    logic               pop;
    cmd_t               head;

    tia_cmd_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
        .clk       (clk),
        .reset_bar (reset_bar),
        .push      (push),
        .push_data ({cmd_addr, cmd_data}),
        .pop       (pop),
        .pop_data  (head),
        .level     (fifo_level)
    );

    // Ready is held low through reset and opens on the first clock afterwards.
    assign cmd_ready = ready_en_reg && (fifo_level != LW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign boundary  = (ph_reg == 2'(CPU_PHASES - 1));
    assign phi2      = (ph_reg != 2'(CPU_PHASES - 1));
    assign a         = a_reg;
    assign d         = d_reg;
    assign w_bar     = w_bar_reg;
    assign cpu_cycle = cycle_reg;
    assign stalled   = (state_reg == STALL);

    always_comb begin
        ph_next    = boundary ? 2'd0 : ph_reg + 2'd1;
        state_next = state_reg;
        a_next     = a_reg;
        d_next     = d_reg;
        w_bar_next = w_bar_reg;
        cycle_next = cycle_reg;
        pop        = 1'b0;
        if (boundary) begin
            cycle_next = cycle_reg + 1'b1;
            a_next     = IDLE_ADDR;
            d_next     = 8'h00;
            w_bar_next = 1'b1;
            // A released stall falls straight into the RUN rule on the same boundary.
            if (state_reg == RUN || rdy) begin
                state_next = RUN;
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    a_next     = head.addr;
                    d_next     = head.data;
                    w_bar_next = 1'b0;
                    if (head.addr == WSYNC_ADDR) state_next = STALL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            ph_reg       <= 2'd0;
            state_reg    <= RUN;
            a_reg        <= IDLE_ADDR;
            d_reg        <= 8'h00;
            w_bar_reg    <= 1'b1;
            cycle_reg    <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            ph_reg       <= ph_next;
            state_reg    <= state_next;
            a_reg        <= a_next;
            d_reg        <= d_next;
            w_bar_reg    <= w_bar_next;
            cycle_reg    <= cycle_next;
            ready_en_reg <= 1'b1;
        end
    end

endmodule
